uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Serial UART receive engine that sits directly upstream of the APB register block. It oversamples serial_in on the system clock using the APB-programmed bit_period and data_size. It deframes start, data and stop bits, and presents the received byte plus status flags (data_ready, overrun_error, framing_error) to the register block. Those flags are cleared by the register block's data_read strobe.

Parameters:
SYNC_STAGES, 2, number of input synchronizer flops on serial_in (legal values >= 2)

Ports:
clk  input  1  system clock; all logic on the rising edge
n_rst  input  1  reset, synchronous and active-low
serial_in  input  1  asynchronous UART line; idle high, LSB first
data_read  input  1  one-cycle strobe from the register block when the data buffer is read
data_size  input  4  data bits per frame; legal values 5..8
bit_period  input  14  clk cycles per bit
rx_data  output  8  last received data, zero-extended when data_size < 8
data_ready  output  1  new data available and not yet read
overrun_error  output  1  a frame was loaded while data_ready was still set
framing_error  output  1  stop bit of the last loaded frame sampled low
rx_busy  output  1  high in START, DATA and STOP states

Behaviour:
- Reset (n_rst low at a clk edge), with priority over all other activity and allowed mid-frame:
  - rx_data = 0x00; data_ready, overrun_error, framing_error, rx_busy = 0.
  - State = IDLE; synchronizer flops = 1; edge-detect register = 1.
- Synchronizer: serial_in passes through SYNC_STAGES flops to form sync_in. An edge-detect register holds the previous sync_in value.
- Config latch: on the IDLE->START transition, bit_period and data_size are captured into internal registers and held for the whole frame. APB writes made mid-frame apply to the next frame.
  - Captured data_size outside 5..8 is treated as 8.
  - Captured bit_period below 4 is treated as 4.
- Timer: 14-bit cycle counter (tmr). It is set to 1 on each state entry and on each bit sample, and increments every cycle otherwise.
- States:
  - IDLE: enter START when the previous sync_in = 1 and the current sync_in = 0 (falling edge). A line held low out of reset never starts a frame.
  - START: when tmr == floor(bp/2), sample sync_in. If 0, go to DATA (bit_cnt = 0). If 1, treat as a false start and return to IDLE with no output change.
  - DATA: when tmr == bp, sample sync_in into the shift register, LSB first, and increment bit_cnt. When bit_cnt reaches the captured data_size, go to STOP.
  - STOP: when tmr == bp, sample the stop bit, perform the load, and go to IDLE.
- Load (registered, visible the cycle after the stop sample):
  - rx_data = received bits right-aligned, upper bits 0.
  - data_ready = 1.
  - framing_error = ~stop_bit.
  - overrun_error = (data_ready & ~data_read) | (overrun_error & ~data_read).
  - Data is loaded even when a framing error is detected; the new frame overwrites the unread one.
- data_read with no load in the same cycle: clears data_ready, overrun_error and framing_error on the next edge. rx_data is held.
- data_read coinciding with a load: the load wins (data_ready = 1), and overrun_error is not set by that load.
- Back-to-back frames: the stop bit is sampled mid-bit, so a start edge arriving half a bit after the stop sample is detected normally.
- rx_busy is a registered decode of state != IDLE.

Test Plan:
1. bp=10, data_size=8, send 0xA5 with a good stop bit -> exactly one load; rx_data=0xA5, data_ready=1, both errors 0; load visible 2+5+80+10+1 = 98 cycles after the serial_in falling edge (±1).
2. bp=10, data_size=5, send bits 10101 (value 0x15) -> rx_data=0x15, bits [7:5]=0; then pulse data_read -> data_ready=0 next cycle, rx_data still 0x15.
3. bp=10, send 0x3C with the stop bit driven low -> rx_data=0x3C, data_ready=1, framing_error=1; the next good frame after data_read leaves framing_error=0.
4. bp=16, send 0x11 then 0x22 with no data_read -> rx_data=0x22, overrun_error=1, data_ready=1; data_read issued on the exact load cycle of a third frame -> data_ready=1, overrun_error=0.
5. bp=10, drive a 3-cycle low glitch on serial_in -> returns to IDLE after the START sample; data_ready stays 0, rx_busy pulses, no load.
6. Assert n_rst mid-DATA of a 0xFF frame, then release -> all outputs 0, state IDLE; a subsequent 0x5A frame is received correctly. Changing bit_period from 10 to 20 mid-frame does not affect the current frame, which decodes at 10.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes serial_in, deframes start/data/stop bits using a
// per-frame latched bit period and data size, and holds the last byte with status flags.
module uart_rx_core #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        serial_in,
    input  logic        data_read,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    output logic [7:0]  rx_data,
    output logic        data_ready,
    output logic        overrun_error,
    output logic        framing_error,
    output logic        rx_busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   warm_q;
    logic                   sync_in;
    logic                   prev_q;
    logic                   armed;

    logic [1:0]  state_q, state_d;
    logic [13:0] tmr_q, tmr_d;
    logic [13:0] bp_q, bp_d;
    logic [3:0]  ds_q, ds_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        load;

    assign sync_in = sync_q[SYNC_STAGES-1];
    // Edges are ignored until the synchronizer and edge register hold real line samples,
    // so a line held low out of reset never looks like a start bit.
    assign armed   = warm_q[SYNC_STAGES];

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + 14'd1;
        bp_d      = bp_q;
        ds_d      = ds_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        load      = 1'b0;
        case (state_q)
            StIdle: begin
                if (armed && prev_q && !sync_in) begin
                    state_d = StStart;
                    tmr_d   = 14'd1;
                    bp_d    = (bit_period < 14'd4) ? 14'd4 : bit_period;
                    ds_d    = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;
                end
            end
            StStart: begin
                if (tmr_q == (bp_q >> 1)) begin
                    tmr_d = 14'd1;
                    if (!sync_in) begin
                        state_d   = StData;
                        bit_cnt_d = 4'd0;
                        shreg_d   = 8'h00;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tmr_q == bp_q) begin
                    tmr_d                     = 14'd1;
                    shreg_d[bit_cnt_q[2:0]]   = sync_in;
                    bit_cnt_d                 = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == ds_q) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tmr_q == bp_q) begin
                    tmr_d   = 14'd1;
                    load    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q        <= '1;
            warm_q        <= '0;
            prev_q        <= 1'b1;
            state_q       <= StIdle;
            tmr_q         <= 14'd1;
            bp_q          <= 14'd4;
            ds_q          <= 4'd8;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= 8'h00;
            rx_data       <= 8'h00;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], serial_in};
            warm_q    <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            prev_q    <= sync_in;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bp_q      <= bp_d;
            ds_q      <= ds_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rx_busy   <= (state_d != StIdle);
            // A load beats a coinciding read; the read only suppresses the overrun.
            if (load) begin
                rx_data       <= shreg_q;
                data_ready    <= 1'b1;
                framing_error <= ~sync_in;
                overrun_error <= (data_ready | overrun_error) & ~data_read;
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
                framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a line-level frame model queues expected results and a
// monitor checks them each time the receiver drops rx_busy.
module tb_uart_rx_core;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        serial_in = 1'b1;
    logic        data_read = 1'b0;
    logic [3:0]  data_size = 4'd8;
    logic [13:0] bit_period = 14'd10;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;
    logic        rx_busy;

    uart_rx_core #(.SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .data_size     (data_size),
        .bit_period    (bit_period),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        bit         rdy;
        bit         ovr;
        bit         fe;
        int         lat;
        int         start;
    } exp_t;

    exp_t sb[$];

    // Reference view of the register-block-facing state.
    logic [7:0] m_data = 8'h00;
    bit m_rdy = 1'b0;
    bit m_ovr = 1'b0;
    bit m_fe  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_rx_data"}, int'(rx_data), int'(m_data));
        chk({tag, "_data_ready"}, int'(data_ready), int'(m_rdy));
        chk({tag, "_overrun"}, int'(overrun_error), int'(m_ovr));
        chk({tag, "_framing"}, int'(framing_error), int'(m_fe));
    endtask

    task automatic do_reset(input logic line, input int n);
        serial_in = line;
        data_read = 1'b0;
        n_rst     = 1'b0;
        repeat (n) tick();
        n_rst  = 1'b1;
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
    endtask

    task automatic read_buf();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        check_flags("read");
    endtask

    // Sends one frame at the receiver's effective baud; optionally strobes data_read on the
    // load cycle and/or reprograms bit_period once the start bit is on the line.
    task automatic send_frame(input int bp_in, input int ds_in, input logic [7:0] d,
                              input bit stop, input bit rd_at_load, input int gap,
                              input int bp_mid);
        int ebp, eds, lat, total, idx;
        logic [7:0] mask;
        exp_t e;
        ebp = (bp_in < 4) ? 4 : bp_in;
        eds = (ds_in >= 5 && ds_in <= 8) ? ds_in : 8;
        lat = SYNC + 1 + ebp / 2 + ebp * (eds + 1);
        bit_period = 14'(bp_in);
        data_size  = 4'(ds_in);
        mask   = 8'((1 << eds) - 1);
        m_data = d & mask;
        m_fe   = !stop;
        m_ovr  = rd_at_load ? 1'b0 : (m_rdy | m_ovr);
        m_rdy  = 1'b1;
        e = '{m_data, m_rdy, m_ovr, m_fe, lat, cyc};
        sb.push_back(e);
        total = ebp * (eds + 2) + gap;
        if (total < lat + 1) total = lat + 1;
        for (int t = 0; t < total; t++) begin
            if (t < ebp) serial_in = 1'b0;
            else if (t < ebp * (eds + 1)) begin
                idx = t / ebp - 1;
                serial_in = d[idx];
            end
            else if (t < ebp * (eds + 2)) serial_in = stop;
            else serial_in = 1'b1;
            data_read = rd_at_load && (t == lat - 1);
            if (bp_mid > 0 && t == ebp) bit_period = 14'(bp_mid);
            tick();
        end
        data_read = 1'b0;
    endtask

    task automatic glitch();
        exp_t e;
        bit_period = 14'd10;
        data_size  = 4'd8;
        e = '{m_data, m_rdy, m_ovr, m_fe, 0, cyc};
        sb.push_back(e);
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (30) tick();
    endtask

    // Monitor: every rx_busy fall outside reset ends a frame attempt and must match the queue.
    initial begin : monitor
        bit   pb;
        int   act;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                pb = 1'b0;
            end else begin
                if (pb && !rx_busy) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame_end: got rx_data %0h with empty queue at cycle %0d",
                                 rx_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("mon_rx_data", int'(rx_data), int'(e.data));
                        chk("mon_data_ready", int'(data_ready), int'(e.rdy));
                        chk("mon_overrun", int'(overrun_error), int'(e.ovr));
                        chk("mon_framing", int'(framing_error), int'(e.fe));
                        if (e.lat > 0) begin
                            act = cyc - e.start;
                            checks++;
                            if (act < e.lat - 1 || act > e.lat + 1) begin
                                errors++;
                                $display("FAIL load_latency: got %0d cycles expected %0d", act, e.lat);
                            end
                        end
                    end
                end
                pb = rx_busy;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        int bp_in, ds_in, pol, gap;
        bit stop;
        logic [7:0] d;

        n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        check_flags("reset");
        chk("reset_busy", int'(rx_busy), 0);
        repeat (20) tick();

        send_frame(10, 8, 8'hA5, 1'b1, 1'b0, 4, 0);
        send_frame(10, 5, 8'hF5, 1'b1, 1'b0, 4, 0);
        read_buf();
        send_frame(10, 8, 8'h3C, 1'b0, 1'b0, 4, 0);
        read_buf();
        send_frame(10, 8, 8'h81, 1'b1, 1'b0, 4, 0);
        read_buf();
        send_frame(16, 8, 8'h11, 1'b1, 1'b0, 0, 0);
        send_frame(16, 8, 8'h22, 1'b1, 1'b0, 0, 0);
        send_frame(16, 8, 8'h33, 1'b1, 1'b1, 4, 0);
        read_buf();
        glitch();

        // Abort a 0xFF frame mid-data with reset, then receive while bit_period changes.
        bit_period = 14'd10;
        data_size  = 4'd8;
        serial_in  = 1'b0;
        repeat (10) tick();
        serial_in = 1'b1;
        repeat (25) tick();
        do_reset(1'b1, 2);
        check_flags("reset_mid");
        chk("reset_mid_busy", int'(rx_busy), 0);
        repeat (10) tick();
        send_frame(10, 8, 8'h5A, 1'b1, 1'b0, 5, 20);
        read_buf();

        // Line held low through and after reset must not start a frame.
        do_reset(1'b0, 3);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rx_busy) seen = 1'b1;
        end
        chk("low_line_busy", int'(seen), 0);
        serial_in = 1'b1;
        repeat (20) tick();

        for (int i = 0; i < 40; i++) begin
            bp_in = int'($urandom_range(2, 24));
            if ($urandom_range(0, 9) == 0) ds_in = int'($urandom_range(0, 15));
            else ds_in = int'($urandom_range(5, 8));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pol  = int'($urandom_range(0, 2));
            gap  = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
            send_frame(bp_in, ds_in, d, stop, pol == 2, gap, 0);
            if (pol == 1) read_buf();
        end

        repeat (50) tick();
        chk("queue_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
